// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: FSM states, program entry table, halt encoding.
package fetch_pkg;
  localparam int PC_W    = 8;
  localparam int INSTR_W = 9;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  // Entry address per ProgSel; slot 3 is the illegal select and never used as a target.
  localparam logic [3:0][PC_W-1:0] PROG_BASE = {8'd0, 8'd45, 8'd26, 8'd0};

  localparam logic [INSTR_W-1:0] HALT_WORD = '0;
endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones; clear has priority over enable.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (!rst_n)                cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (en && cnt != '1)  cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/fetch_sequencer.sv
// PC sequencer: starts a resident program, advances/stalls/branches each cycle, stops on the halt word.
module fetch_sequencer #(
  parameter int PC_W       = fetch_pkg::PC_W,
  parameter int INSTR_W    = fetch_pkg::INSTR_W,
  parameter int CYC_W      = 16,
  parameter int PROG0_BASE = int'(fetch_pkg::PROG_BASE[0]),
  parameter int PROG1_BASE = int'(fetch_pkg::PROG_BASE[1]),
  parameter int PROG2_BASE = int'(fetch_pkg::PROG_BASE[2])
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic [1:0]         ProgSel,
  input  logic [INSTR_W-1:0] Instr,
  input  logic               Stall,
  input  logic               BranchTaken,
  input  logic [PC_W-1:0]    BranchTarget,
  output logic [PC_W-1:0]    PC,
  output logic               InstrValid,
  output logic               Busy,
  output logic               Done,
  output logic [CYC_W-1:0]   CycleCount,
  output logic               Fault
);
  import fetch_pkg::*;

  localparam logic [3:0][PC_W-1:0] BASES = {
    PC_W'(0), PC_W'(PROG2_BASE), PC_W'(PROG1_BASE), PC_W'(PROG0_BASE)
  };

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic            done_nxt, fault_nxt, start_ok, is_halt;

  assign is_halt    = (Instr == INSTR_W'(HALT_WORD));
  assign Busy       = (state == RUN);
  assign InstrValid = Busy && !is_halt && !Stall;

  always_comb begin
    state_nxt = state;
    pc_nxt    = PC;
    done_nxt  = Done;
    fault_nxt = Fault;
    start_ok  = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start) begin
          if (ProgSel != 2'd3) begin
            start_ok  = 1'b1;
            pc_nxt    = BASES[ProgSel];
            done_nxt  = 1'b0;
            fault_nxt = 1'b0;
            state_nxt = RUN;
          end else begin
            fault_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        // Halt outranks stall and branch; a branch during stall is re-presented later.
        if (is_halt) begin
          done_nxt  = 1'b1;
          state_nxt = HALT;
        end else if (Stall) begin
          pc_nxt = PC;
        end else if (BranchTaken) begin
          pc_nxt = BranchTarget;
        end else if (PC == '1) begin
          // Running off the top of memory is a fault, never a wrap to 0.
          fault_nxt = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = HALT;
        end else begin
          pc_nxt = PC + 1'b1;
        end
      end
      HALT: begin
        if (!Start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= IDLE;
      PC    <= '0;
      Done  <= 1'b0;
      Fault <= 1'b0;
    end else begin
      state <= state_nxt;
      PC    <= pc_nxt;
      Done  <= done_nxt;
      Fault <= fault_nxt;
    end
  end

  sat_counter #(.W(CYC_W)) u_cyc (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (start_ok),
    .en    (state == RUN),
    .cnt   (CycleCount)
  );
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed + random bench for fetch_sequencer against a cycle-level behavioural model.
module tb_fetch_sequencer;
  logic       clk = 1'b0;
  logic       reset_n, start, stall, branch_taken;
  logic [1:0] prog_sel;
  logic [8:0] instr;
  logic [7:0] branch_target, pc;
  logic       instr_valid, busy, done, fault;
  logic [15:0] cycle_count;

  logic [8:0] imem [256];
  int checks = 0, errors = 0;

  // model state: mode 0=idle, 1=running, 2=halted
  int m_mode, m_pc, m_cnt;
  bit m_done, m_fault;
  int base [3] = '{0, 26, 45};

  always #5 clk = ~clk;
  assign instr = imem[pc];

  fetch_sequencer dut (
    .Clk(clk), .Reset_n(reset_n), .Start(start), .ProgSel(prog_sel),
    .Instr(instr), .Stall(stall), .BranchTaken(branch_taken),
    .BranchTarget(branch_target), .PC(pc), .InstrValid(instr_valid),
    .Busy(busy), .Done(done), .CycleCount(cycle_count), .Fault(fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (!reset_n) begin
      m_mode = 0; m_pc = 0; m_done = 0; m_fault = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      if (start) begin
        if (prog_sel == 2'd3) m_fault = 1;
        else begin
          m_mode = 1; m_pc = base[prog_sel]; m_cnt = 0; m_done = 0; m_fault = 0;
        end
      end
    end else if (m_mode == 1) begin
      if (m_cnt < 65535) m_cnt++;
      if (imem[m_pc] == 0) begin m_done = 1; m_mode = 2; end
      else if (stall) ;
      else if (branch_taken) m_pc = int'(branch_target);
      else if (m_pc == 255) begin m_fault = 1; m_done = 1; m_mode = 2; end
      else m_pc++;
    end else begin
      if (!start) m_mode = 0;
    end
  endtask

  task automatic tick(input string tag, input bit comb = 1'b1);
    bit halt_w;
    #1;
    halt_w = (imem[m_pc] == 0);
    if (comb) begin
      chk({tag, "/busy"},   32'(busy),        32'(m_mode == 1));
      chk({tag, "/ivalid"}, 32'(instr_valid), 32'(m_mode == 1 && !halt_w && !stall));
    end
    model_step();
    @(posedge clk); #1;
    chk({tag, "/pc"},    32'(pc),          32'(m_pc));
    chk({tag, "/done"},  32'(done),        32'(m_done));
    chk({tag, "/fault"}, 32'(fault),       32'(m_fault));
    chk({tag, "/cnt"},   32'(cycle_count), 32'(m_cnt));
  endtask

  task automatic go(input string tag, input logic [1:0] sel);
    start = 1; prog_sel = sel;
    tick({tag, "/start"});
    start = 0;
  endtask

  // Run until halted; optional stall window and one branch (branch also held during stall).
  task automatic run_prog(input string tag, input int stall_pc, input int stall_n,
                          input int br_pc, input int br_tgt);
    int left = stall_n;
    for (int i = 0; i < 400 && m_mode == 1; i++) begin
      stall = (m_pc == stall_pc && left > 0);
      if (stall) left--;
      branch_taken  = stall || (m_pc == br_pc);
      branch_target = stall ? 8'd200 : 8'(br_tgt);
      tick(tag);
    end
    stall = 0; branch_taken = 0;
    chk({tag, "/finished"}, 32'(done), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 9'($urandom_range(1, 511));
    imem[25] = 9'd0; imem[44] = 9'd0; imem[80] = 9'd0;
    m_mode = 0; m_pc = 0; m_cnt = 0; m_done = 0; m_fault = 0;
    stall = 0; branch_taken = 0; branch_target = 0;

    // reset held with Start asserted
    reset_n = 0; start = 1; prog_sel = 0;
    tick("rst0", 1'b0);
    tick("rst1");
    chk("rst/pc", 32'(pc), 0);
    chk("rst/cnt", 32'(cycle_count), 0);
    reset_n = 1; start = 0;
    tick("idle");

    // program 0 straight-line
    go("p0", 2'd0);
    chk("p0/base", 32'(pc), 0);
    run_prog("p0", -1, 0, -1, 0);
    chk("p0/pc_end", 32'(pc), 25);
    chk("p0/cnt_end", 32'(cycle_count), 26);
    tick("p0/toidle");

    // program 0 with a 3-cycle stall at PC 5, branch ignored while stalled
    go("p0s", 2'd0);
    run_prog("p0s", 5, 3, -1, 0);
    chk("p0s/pc_end", 32'(pc), 25);
    chk("p0s/cnt_end", 32'(cycle_count), 29);
    tick("p0s/toidle");

    // program 1 with branch 32 -> 39
    go("p1", 2'd1);
    chk("p1/base", 32'(pc), 26);
    run_prog("p1", -1, 0, 32, 39);
    chk("p1/pc_end", 32'(pc), 44);
    chk("p1/cnt_end", 32'(cycle_count), 13);
    tick("p1/toidle");

    // illegal select, then recovery with program 2
    start = 1; prog_sel = 2'd3;
    tick("ill");
    chk("ill/fault", 32'(fault), 1);
    chk("ill/pc", 32'(pc), 44);
    prog_sel = 2'd2;
    tick("ill/recover");
    start = 0;
    chk("ill/clr", 32'(fault), 0);
    chk("ill/base", 32'(pc), 45);

    // abort program 2 with reset at PC 50
    for (int i = 0; i < 20 && m_pc != 50; i++) tick("p2");
    chk("abort/at50", 32'(pc), 50);
    reset_n = 0;
    tick("abort");
    reset_n = 1;
    chk("abort/pc", 32'(pc), 0);
    chk("abort/done", 32'(done), 0);
    chk("abort/cnt", 32'(cycle_count), 0);
    tick("abort/idle");

    // run off the top of memory: branch 46 -> 250, fault at 255
    go("wrap", 2'd2);
    run_prog("wrap", -1, 0, 46, 250);
    chk("wrap/pc", 32'(pc), 255);
    chk("wrap/fault", 32'(fault), 1);
    chk("wrap/cnt", 32'(cycle_count), 8);
    tick("wrap/toidle");

    // random traffic
    for (int i = 0; i < 600; i++) begin
      reset_n       = ($urandom_range(0, 59) != 0);
      start         = ($urandom_range(0, 3) == 0);
      prog_sel      = 2'($urandom_range(0, 3));
      stall         = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 5) == 0);
      branch_target = 8'($urandom_range(0, 255));
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
